// File: rtl/dm_if.sv
// Data-port and trace-drain bundle for dm_responder.
// The master side is the core and the trace consumer; the slave side is the responder.
interface dm_if;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic        trace_overflow;
  logic        err_oor;
  logic        err_align;

  modport master (
    output m_data_addr,
    output m_data_wdata,
    output m_data_byteen,
    output m_inst_addr,
    output trace_ready,
    input  m_data_rdata,
    input  trace_valid,
    input  trace_pc,
    input  trace_addr,
    input  trace_data,
    input  trace_overflow,
    input  err_oor,
    input  err_align
  );

  modport slave (
    input  m_data_addr,
    input  m_data_wdata,
    input  m_data_byteen,
    input  m_inst_addr,
    input  trace_ready,
    output m_data_rdata,
    output trace_valid,
    output trace_pc,
    output trace_addr,
    output trace_data,
    output trace_overflow,
    output err_oor,
    output err_align
  );
endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: combinational read, byte-masked write, write-trace FIFO.
// Define DM_ALIGN_CHECK_EN to reject illegal lane/offset combinations.
module dm_responder #(
  parameter int DEPTH_WORDS = 3072,
  parameter int AW          = 12,
  parameter int TRACE_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  dm_if.slave bus
);
  localparam int PW = $clog2(TRACE_DEPTH);
  localparam logic [29:0] LIMIT = 30'(DEPTH_WORDS);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(TRACE_DEPTH);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] tpc_q [TRACE_DEPTH];
  logic [31:0] tadr_q [TRACE_DEPTH];
  logic [31:0] tdat_q [TRACE_DEPTH];

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          oor_q, oor_d;
  logic          aln_q, aln_d;

  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic          in_range;
  logic          any_be;
  logic          align_ok;
  logic          wr_en;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [31:0]   cur;
  logic [31:0]   merged;
  logic [31:0]   wadr;

  assign idx      = bus.m_data_addr[AW+1:2];
  assign off      = bus.m_data_addr[1:0];
  assign in_range = bus.m_data_addr[31:2] < LIMIT;
  assign any_be   = |bus.m_data_byteen;
  assign wadr     = {bus.m_data_addr[31:2], 2'b00};
  assign cur      = in_range ? mem_q[idx] : 32'h0;

`ifdef DM_ALIGN_CHECK_EN
  // Only naturally aligned byte, half and word lane patterns are legal
  always_comb begin
    align_ok = 1'b0;
    case (bus.m_data_byteen)
      4'b1111: align_ok = (off == 2'd0);
      4'b0011: align_ok = (off == 2'd0);
      4'b1100: align_ok = (off == 2'd2);
      4'b0001: align_ok = (off == 2'd0);
      4'b0010: align_ok = (off == 2'd1);
      4'b0100: align_ok = (off == 2'd2);
      4'b1000: align_ok = (off == 2'd3);
      default: align_ok = 1'b0;
    endcase
  end
`else
  logic unused_off;
  assign unused_off = ^off;
  assign align_ok   = 1'b1;
`endif

  // Merge enabled write lanes over the current word
  always_comb begin
    merged = cur;
    for (int i = 0; i < 4; i++) begin
      if (bus.m_data_byteen[i])
        merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
    end
  end

  // Trace FIFO control and error next-state
  always_comb begin
    wr_en = any_be && in_range && align_ok && !reset;
    full  = (cnt_q == FULL_CNT);
    empty = (cnt_q == '0);
    pop   = !empty && bus.trace_ready;
    push  = wr_en && (!full || pop);
    wp_d  = wp_q + PW'(push);
    rp_d  = rp_q + PW'(pop);
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    ovf_d = ovf_q | (wr_en && full && !pop);
    oor_d = !in_range &&
            (any_be || bus.m_data_addr != 32'hFFFF_FFFF);
    aln_d = any_be && !align_ok;
  end

  // Memory array: cleared on reset, byte-merged on write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++)
        mem_q[i] <= 32'h0;
    end else if (wr_en) begin
      mem_q[idx] <= merged;
    end
  end

  // Trace entry storage; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      tpc_q[wp_q]  <= bus.m_inst_addr;
      tadr_q[wp_q] <= wadr;
      tdat_q[wp_q] <= merged;
    end
  end

  // Pointers, count, sticky overflow and error pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      oor_q <= 1'b0;
      aln_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      oor_q <= oor_d;
      aln_q <= aln_d;
    end
  end

  assign bus.m_data_rdata   = cur;
  assign bus.trace_valid    = !empty;
  assign bus.trace_pc       = empty ? 32'h0 : tpc_q[rp_q];
  assign bus.trace_addr     = empty ? 32'h0 : tadr_q[rp_q];
  assign bus.trace_data     = empty ? 32'h0 : tdat_q[rp_q];
  assign bus.trace_overflow = ovf_q;
  assign bus.err_oor        = oor_q;
`ifdef DM_ALIGN_CHECK_EN
  assign bus.err_align      = aln_q;
`else
  logic unused_aln;
  assign unused_aln         = aln_q;
  assign bus.err_align      = 1'b0;
`endif
endmodule

// File: tb/tb_dm_responder.sv
// Directed self-checking bench for dm_responder.
// One task per scenario, run in sequence.
module tb_dm_responder;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  dm_if bus();

  dm_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_data_addr   = 32'hFFFF_FFFF;
    bus.m_data_wdata  = 32'h0;
    bus.m_data_byteen = 4'b0000;
    bus.m_inst_addr   = 32'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] be,
                    input logic [31:0] d, input logic [31:0] pc);
    bus.m_data_addr   = a;
    bus.m_data_byteen = be;
    bus.m_data_wdata  = d;
    bus.m_inst_addr   = pc;
  endtask

  task automatic test_reset();
    idle();
    bus.trace_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.m_data_addr = 32'h0;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_rd0 got %h want %h", bus.m_data_rdata, 32'h0);
    end
    bus.m_data_addr = 32'h2FFC;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_rd2ffc got %h want %h", bus.m_data_rdata, 32'h0);
    end
    n_cmp++;
    if ({bus.trace_valid, bus.trace_overflow, bus.err_oor, bus.err_align} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 0000",
               {bus.trace_valid, bus.trace_overflow, bus.err_oor, bus.err_align});
    end
    n_cmp++;
    if (bus.trace_pc !== 32'h0 || bus.trace_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_trace got %h/%h want 0/0", bus.trace_pc, bus.trace_data);
    end
    idle();
  endtask

  task automatic test_full_write();
    wr(32'h10, 4'b1111, 32'hDEADBEEF, 32'h3000);
    tick();
    idle();
    bus.m_data_addr = 32'h10;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL fw_rd got %h want %h", bus.m_data_rdata, 32'hDEADBEEF);
    end
    n_cmp++;
    if (bus.trace_valid !== 1'b1 || bus.trace_pc !== 32'h3000 ||
        bus.trace_addr !== 32'h10 || bus.trace_data !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL fw_head got v=%b %h %h %h want v=1 3000 10 deadbeef",
               bus.trace_valid, bus.trace_pc, bus.trace_addr, bus.trace_data);
    end
    bus.trace_ready = 1'b1;
    tick();
    bus.trace_ready = 1'b0;
    n_cmp++;
    if (bus.trace_valid !== 1'b0 || bus.trace_pc !== 32'h0) begin
      n_bad++;
      $display("FAIL fw_pop got v=%b pc=%h want v=0 pc=0", bus.trace_valid, bus.trace_pc);
    end
  endtask

  task automatic test_partial();
    wr(32'h12, 4'b1100, 32'h12341234, 32'h3004);
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'hDEADBEEF) begin
      n_bad++;
      $display("FAIL pw_preedge got %h want %h", bus.m_data_rdata, 32'hDEADBEEF);
    end
    tick();
    n_cmp++;
    if (bus.m_data_rdata !== 32'h1234BEEF) begin
      n_bad++;
      $display("FAIL pw_half got %h want %h", bus.m_data_rdata, 32'h1234BEEF);
    end
    wr(32'h11, 4'b0010, 32'h55555555, 32'h3008);
    tick();
    idle();
    bus.m_data_addr = 32'h10;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h123455EF) begin
      n_bad++;
      $display("FAIL pw_byte got %h want %h", bus.m_data_rdata, 32'h123455EF);
    end
    n_cmp++;
    if (bus.trace_addr !== 32'h10 || bus.trace_data !== 32'h1234BEEF ||
        bus.trace_pc !== 32'h3004) begin
      n_bad++;
      $display("FAIL pw_head got %h %h %h want 3004 10 1234beef",
               bus.trace_pc, bus.trace_addr, bus.trace_data);
    end
    bus.trace_ready = 1'b1;
    tick();
    n_cmp++;
    if (bus.trace_data !== 32'h123455EF || bus.trace_pc !== 32'h3008) begin
      n_bad++;
      $display("FAIL pw_head2 got %h %h want 3008 123455ef", bus.trace_pc, bus.trace_data);
    end
    tick();
    bus.trace_ready = 1'b0;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 9; i++) begin
      wr(32'h100 + 32'(4*i), 4'b1111, 32'hA000_0000 + 32'(i), 32'h4000 + 32'(4*i));
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if (bus.trace_overflow !== 1'b1 || bus.trace_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flag got ovf=%b v=%b want 1 1", bus.trace_overflow, bus.trace_valid);
    end
    bus.trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if (bus.trace_pc !== 32'h4000 + 32'(4*i) ||
          bus.trace_data !== 32'hA000_0000 + 32'(i)) begin
        n_bad++;
        $display("FAIL ovf_pop%0d got %h %h want %h %h", i, bus.trace_pc, bus.trace_data,
                 32'h4000 + 32'(4*i), 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    bus.trace_ready = 1'b0;
    n_cmp++;
    if (bus.trace_valid !== 1'b0 || bus.trace_overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_empty got v=%b ovf=%b want 0 1", bus.trace_valid, bus.trace_overflow);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      wr(32'h200 + 32'(4*i), 4'b1111, 32'hB0 + 32'(i), 32'h5000 + 32'(4*i));
      tick();
    end
    wr(32'h220, 4'b1111, 32'hB8, 32'h5020);
    bus.trace_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.trace_pc !== 32'h5000) begin
      n_bad++;
      $display("FAIL b2b_head got %h want %h", bus.trace_pc, 32'h5000);
    end
    tick();
    idle();
    for (int j = 1; j < 9; j++) begin
      #1;
      n_cmp++;
      if (bus.trace_pc !== 32'h5000 + 32'(4*j) ||
          bus.trace_data !== 32'hB0 + 32'(j)) begin
        n_bad++;
        $display("FAIL b2b_pop%0d got %h %h want %h %h", j, bus.trace_pc, bus.trace_data,
                 32'h5000 + 32'(4*j), 32'hB0 + 32'(j));
      end
      tick();
    end
    bus.trace_ready = 1'b0;
    n_cmp++;
    if (bus.trace_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_empty got %b want 0", bus.trace_valid);
    end
  endtask

  task automatic test_oor();
    wr(32'h3000, 4'b1111, 32'hFFFF_FFFF, 32'h6000);
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_rd got %h want 0", bus.m_data_rdata);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (bus.err_oor !== 1'b1 || bus.trace_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_pulse got oor=%b v=%b want 1 0", bus.err_oor, bus.trace_valid);
    end
    tick();
    n_cmp++;
    if (bus.err_oor !== 1'b0) begin
      n_bad++;
      $display("FAIL oor_clear got %b want 0", bus.err_oor);
    end
    bus.m_data_addr = 32'h2FFC;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL oor_last got %h want 0", bus.m_data_rdata);
    end
    bus.m_data_addr = 32'h3000;
    tick();
    n_cmp++;
    if (bus.err_oor !== 1'b1) begin
      n_bad++;
      $display("FAIL oor_read got %b want 1", bus.err_oor);
    end
    idle();
    tick();
  endtask

  task automatic test_align();
    wr(32'h2, 4'b0011, 32'hCAFEF00D, 32'h7000);
    tick();
    idle();
    bus.m_data_addr = 32'h0;
    #1;
`ifdef DM_ALIGN_CHECK_EN
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0 || bus.err_align !== 1'b1 || bus.trace_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL aln_chk got %h e=%b v=%b want 0 1 0",
               bus.m_data_rdata, bus.err_align, bus.trace_valid);
    end
`else
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0000F00D || bus.err_align !== 1'b0 ||
        bus.trace_valid !== 1'b1 || bus.trace_addr !== 32'h0) begin
      n_bad++;
      $display("FAIL aln_none got %h e=%b v=%b a=%h want 0000f00d 0 1 0",
               bus.m_data_rdata, bus.err_align, bus.trace_valid, bus.trace_addr);
    end
`endif
    tick();
    n_cmp++;
    if (bus.err_align !== 1'b0) begin
      n_bad++;
      $display("FAIL aln_clear got %b want 0", bus.err_align);
    end
  endtask

  task automatic test_reset_wins();
    wr(32'h20, 4'b1111, 32'h11223344, 32'h8000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    bus.m_data_addr = 32'h20;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0 || bus.trace_valid !== 1'b0 ||
        bus.trace_overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL rw_state got %h v=%b ovf=%b want 0 0 0",
               bus.m_data_rdata, bus.trace_valid, bus.trace_overflow);
    end
    bus.m_data_addr = 32'h10;
    #1;
    n_cmp++;
    if (bus.m_data_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL rw_clear got %h want 0", bus.m_data_rdata);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    bus.trace_ready = 1'b0;
    idle();
    test_reset();
    test_full_write();
    test_partial();
    test_overflow();
    test_back_to_back();
    test_oor();
    test_align();
    test_reset_wins();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
